i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h50, 7-bit I2C target address.
REQ-002 SHALL have parameter NREG, default 16, register count, power of two, 2..256.
REQ-003 SHALL have ports, in order:
- clk  input  1  single clock
- reset_n  input  1  reset, synchronous, active-low
- core_i2c_scl_in  input  1  SCL from pad
- core_i2c_scl_out  output  1  SCL drive value
- core_i2c_scl_en  output  1  SCL drive enable
- core_i2c_sda_in  input  1  SDA from pad
- core_i2c_sda_out  output  1  SDA drive value
- core_i2c_sda_en  output  1  SDA drive enable; 1 pulls SDA low
- regs  output  NREG*8  register file; reg i = bits [8i+7:8i]
- wr_stb  output  1  one-cycle pulse on each register write
- wr_idx  output  $clog2(NREG)  index written, valid with wr_stb
REQ-004 SHALL tie core_i2c_scl_out, core_i2c_scl_en and core_i2c_sda_out to 0 (no clock stretching; open-drain only).

Function
REQ-005 SHALL pass core_i2c_scl_in and core_i2c_sda_in through 2-flop synchronizers plus one history flop; all bus decisions use synchronized values.
REQ-006 SHALL detect START as synced SDA 1->0 while synced SCL=1, and STOP as synced SDA 1->0 reversed (0->1) while synced SCL=1.
REQ-007 SHALL sample SDA on synced SCL 0->1 edge and change core_i2c_sda_en only in the cycle after a synced SCL 1->0 edge.
REQ-008 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-009 START from any state SHALL go to ADDR with bit count cleared and SDA released (repeated START supported).
REQ-010 STOP from any state SHALL go to IDLE and release SDA; pointer retained.
REQ-011 ADDR SHALL shift 8 bits MSB first; on 8th bit, if [7:1]==TARGET_ADDR go to ADDR_ACK, else go to IGNORE (no ACK).
REQ-012 ADDR_ACK SHALL drive sda_en=1 for the 9th clock; then go to PTR if R/W=0, or RDATA if R/W=1.
REQ-013 PTR SHALL receive 8 bits, load pointer from low $clog2(NREG) bits (upper bits ignored), ACK, then go to WDATA.
REQ-014 WDATA SHALL receive 8 bits, write regs[ptr], pulse wr_stb with wr_idx=ptr in the cycle the 8th bit is sampled, ACK, increment ptr, return to WDATA.
REQ-015 RDATA SHALL drive regs[ptr] MSB first (sda_en = ~bit), value latched when entering RDATA; after 8th bit release SDA and go to RDATA_ACK.
REQ-016 RDATA_ACK SHALL sample controller ACK on 9th rise: SDA=0 -> ptr+1, RDATA; SDA=1 (NACK) -> IGNORE.
REQ-017 Pointer increment SHALL wrap NREG-1 -> 0.
REQ-018 IGNORE SHALL hold SDA released until START or STOP.
REQ-019 START and STOP SHALL take priority over a simultaneous SCL edge in the same cycle.
REQ-020 A repeated START with read after a pointer write SHALL read from the written pointer.

Reset
REQ-021 With reset_n=0 at a clk rising edge: state IDLE, synchronizers and history flops 1, ptr 0, all regs 8'h00, sda_en 0, wr_stb 0, wr_idx 0.
REQ-022 Reset mid-transfer SHALL abort immediately; the bus is released and the block waits for the next START.

Verification
REQ-023 Write 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK on all 4 bytes; regs[3]=5A, regs[4]=C3; two wr_stb pulses, wr_idx 3 then 4.
REQ-024 After REQ-023: 0xA0, 0x03, Sr, 0xA1, read 2 bytes (ACK, NACK), STOP -> returns 5A, C3; SDA released after NACK.
REQ-025 Write 0xA0, 0x0F, 0x11, 0x22 -> regs[15]=11, regs[0]=22 (pointer wrap).
REQ-026 Address 0xA2 -> no ACK on 9th clock, no wr_stb, sda_en stays 0 until STOP.
REQ-027 reset_n=0 for 2 cycles during the 5th data bit of a read -> sda_en 0 next cycle, regs all 00; next 0xA0 transfer ACKed normally.
REQ-028 STOP after 4 bits of a write byte -> no write, state IDLE, regs unchanged.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREG byte registers: write sets a pointer then stores bytes,
// read returns bytes from the pointer, auto-incrementing with wrap.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NREG        = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    core_i2c_scl_in,
  output logic                    core_i2c_scl_out,
  output logic                    core_i2c_scl_en,
  input  logic                    core_i2c_sda_in,
  output logic                    core_i2c_sda_out,
  output logic                    core_i2c_sda_en,
  output logic [NREG*8-1:0]       regs,
  output logic                    wr_stb,
  output logic [$clog2(NREG)-1:0] wr_idx
);

  localparam int PW = $clog2(NREG);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic r_sclMeta, r_sclSync, r_sclHist;
  logic r_sdaMeta, r_sdaSync, r_sdaHist;
  logic r_fallD;
  logic r_sdaEn;
  logic r_wrStb;
  logic [PW-1:0] r_wrIdx;
  logic [PW-1:0] r_ptr;
  logic [2:0]    r_bitCnt;
  logic [6:0]    r_shift;
  logic [7:0]    r_txByte;
  logic [7:0]    r_regs [NREG];

  logic w_sclRise, w_sclFall, w_start, w_stop, w_lastBit;
  logic [7:0]    w_rxByte;
  logic [PW-1:0] w_ptrInc;
  logic w_clrCnt, w_cntEn, w_shiftEn, w_loadPtr, w_doWrite;
  logic w_loadTx, w_ackInc, w_shiftTx, w_sdaEnNext;

  assign core_i2c_scl_out = 1'b0;
  assign core_i2c_scl_en  = 1'b0;
  assign core_i2c_sda_out = 1'b0;
  assign core_i2c_sda_en  = r_sdaEn;
  assign wr_stb           = r_wrStb;
  assign wr_idx           = r_wrIdx;

  for (genvar g = 0; g < NREG; g++) begin : g_regsOut
    assign regs[8*g +: 8] = r_regs[g];
  end

  assign w_sclRise = r_sclSync & ~r_sclHist;
  assign w_sclFall = ~r_sclSync & r_sclHist;
  assign w_start   = r_sclSync & r_sdaHist & ~r_sdaSync;
  assign w_stop    = r_sclSync & ~r_sdaHist & r_sdaSync;
  assign w_lastBit = (r_bitCnt == 3'd7);
  assign w_rxByte  = {r_shift, r_sdaSync};
  assign w_ptrInc  = r_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sclMeta <= 1'b1;
      r_sclSync <= 1'b1;
      r_sclHist <= 1'b1;
      r_sdaMeta <= 1'b1;
      r_sdaSync <= 1'b1;
      r_sdaHist <= 1'b1;
      r_fallD   <= 1'b0;
    end else begin
      r_sclMeta <= core_i2c_scl_in;
      r_sclSync <= r_sclMeta;
      r_sclHist <= r_sclSync;
      r_sdaMeta <= core_i2c_sda_in;
      r_sdaSync <= r_sdaMeta;
      r_sdaHist <= r_sdaSync;
      r_fallD   <= w_sclFall;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Bus conditions win over SCL edges; SDA drive only moves on the cycle after a fall.
  always_comb begin
    w_stateNext = r_state;
    w_clrCnt    = 1'b0;
    w_cntEn     = 1'b0;
    w_shiftEn   = 1'b0;
    w_loadPtr   = 1'b0;
    w_doWrite   = 1'b0;
    w_loadTx    = 1'b0;
    w_ackInc    = 1'b0;
    w_shiftTx   = 1'b0;
    w_sdaEnNext = r_sdaEn;
    if (w_start) begin
      w_stateNext = ADDR;
      w_clrCnt    = 1'b1;
      w_sdaEnNext = 1'b0;
    end else if (w_stop) begin
      w_stateNext = IDLE;
      w_sdaEnNext = 1'b0;
    end else begin
      if (w_sclRise) begin
        case (r_state)
          ADDR: begin
            w_cntEn   = 1'b1;
            w_shiftEn = 1'b1;
            if (w_lastBit) begin
              w_stateNext = (w_rxByte[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
            end
          end
          ADDR_ACK: begin
            w_stateNext = r_shift[0] ? RDATA : PTR;
            w_loadTx    = r_shift[0];
          end
          PTR: begin
            w_cntEn   = 1'b1;
            w_shiftEn = 1'b1;
            if (w_lastBit) begin
              w_stateNext = PTR_ACK;
              w_loadPtr   = 1'b1;
            end
          end
          PTR_ACK:   w_stateNext = WDATA;
          WDATA: begin
            w_cntEn   = 1'b1;
            w_shiftEn = 1'b1;
            if (w_lastBit) begin
              w_stateNext = WDATA_ACK;
              w_doWrite   = 1'b1;
            end
          end
          WDATA_ACK: w_stateNext = WDATA;
          RDATA: begin
            w_cntEn = 1'b1;
            if (w_lastBit) begin
              w_stateNext = RDATA_ACK;
            end
          end
          RDATA_ACK: begin
            if (!r_sdaSync) begin
              w_stateNext = RDATA;
              w_ackInc    = 1'b1;
            end else begin
              w_stateNext = IGNORE;
            end
          end
          default: w_stateNext = r_state;
        endcase
      end
      if (r_fallD) begin
        case (r_state)
          ADDR_ACK, PTR_ACK, WDATA_ACK: w_sdaEnNext = 1'b1;
          RDATA: begin
            w_sdaEnNext = ~r_txByte[7];
            w_shiftTx   = 1'b1;
          end
          default: w_sdaEnNext = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sdaEn  <= 1'b0;
      r_wrStb  <= 1'b0;
      r_wrIdx  <= '0;
      r_ptr    <= '0;
      r_bitCnt <= 3'd0;
      r_shift  <= 7'd0;
      r_txByte <= 8'h00;
    end else begin
      r_sdaEn <= w_sdaEnNext;
      r_wrStb <= w_doWrite;
      if (w_clrCnt) begin
        r_bitCnt <= 3'd0;
      end else if (w_cntEn) begin
        r_bitCnt <= r_bitCnt + 3'd1;
      end
      if (w_shiftEn) begin
        r_shift <= w_rxByte[6:0];
      end
      if (w_loadPtr) begin
        r_ptr <= w_rxByte[PW-1:0];
      end else if (w_doWrite || w_ackInc) begin
        r_ptr <= w_ptrInc;
      end
      if (w_doWrite) begin
        r_wrIdx <= r_ptr;
      end
      // Next read byte is captured up front so a later write cannot tear it mid-shift.
      if (w_loadTx) begin
        r_txByte <= r_regs[r_ptr];
      end else if (w_ackInc) begin
        r_txByte <= r_regs[w_ptrInc];
      end else if (w_shiftTx) begin
        r_txByte <= {r_txByte[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_doWrite) begin
      r_regs[r_ptr] <= w_rxByte;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: an open-drain controller model drives
// write, read, wrap, wrong-address, reset-abort and early-STOP sequences.
module tb_i2c_target_regs;

  localparam int Q = 8;

  logic         clk;
  logic         reset_n;
  logic         sclCtl;
  logic         sdaCtl;
  logic         sdaLine;
  logic         sclOut, sclEn, sdaOut, sdaEn;
  logic [127:0] regs;
  logic         wrStb;
  logic [3:0]   wrIdx;

  int total;
  int bad;
  int stbCount;
  int stbIdx [64];
  logic enSeen;

  logic [127:0] expRegs;
  logic         ack;
  logic [7:0]   rdByte;
  logic [3:0]   partBits;
  logic         bitVal;
  int           stbBase;

  assign sdaLine = sdaCtl & ~sdaEn;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .NREG(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .core_i2c_scl_in  (sclCtl),
    .core_i2c_scl_out (sclOut),
    .core_i2c_scl_en  (sclEn),
    .core_i2c_sda_in  (sdaLine),
    .core_i2c_sda_out (sdaOut),
    .core_i2c_sda_en  (sdaEn),
    .regs             (regs),
    .wr_stb           (wrStb),
    .wr_idx           (wrIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe and any SDA drive, sampled away from the active edge.
  always @(negedge clk) begin
    if (wrStb) begin
      if (stbCount < 64) stbIdx[stbCount] = int'(wrIdx);
      stbCount++;
    end
    if (sdaEn) enSeen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2cStart();
    sdaCtl = 1'b1; quarter();
    sclCtl = 1'b1; quarter();
    sdaCtl = 1'b0; quarter();
    sclCtl = 1'b0; quarter();
  endtask

  task automatic i2cStop();
    sdaCtl = 1'b0; quarter();
    sclCtl = 1'b1; quarter();
    sdaCtl = 1'b1; quarter();
    quarter();
  endtask

  task automatic writeBit(input logic b);
    sdaCtl = b;    quarter();
    sclCtl = 1'b1; quarter();
    quarter();
    sclCtl = 1'b0; quarter();
  endtask

  task automatic readBit(output logic b);
    sdaCtl = 1'b1; quarter();
    sclCtl = 1'b1; quarter();
    b = sdaLine;   quarter();
    sclCtl = 1'b0; quarter();
  endtask

  task automatic applyStimulus(input logic [7:0] data, output logic ackBit);
    for (int i = 7; i >= 0; i--) writeBit(data[i]);
    readBit(ackBit);
  endtask

  task automatic readByte(output logic [7:0] data, input logic ackBit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      data[i] = b;
    end
    writeBit(ackBit);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    stbCount = 0;
    enSeen   = 1'b0;
    expRegs  = '0;
    reset_n  = 1'b0;
    sclCtl   = 1'b1;
    sdaCtl   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_sda_en", 128'(sdaEn), 128'd0);
    checkOutput("rst_wr_stb", 128'(wrStb), 128'd0);
    checkOutput("rst_wr_idx", 128'(wrIdx), 128'd0);
    checkOutput("rst_regs", regs, 128'd0);
    checkOutput("tie_lines", 128'({sclOut, sclEn, sdaOut}), 128'd0);
    reset_n = 1'b1;
    quarter();

    $display("[TB] write 5A,C3 at pointer 3");
    i2cStart();
    applyStimulus(8'hA0, ack); checkOutput("wr_addr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h03, ack); checkOutput("wr_ptr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h5A, ack); checkOutput("wr_d0_ack", 128'(ack), 128'd0);
    applyStimulus(8'hC3, ack); checkOutput("wr_d1_ack", 128'(ack), 128'd0);
    i2cStop();
    expRegs[3*8 +: 8] = 8'h5A;
    expRegs[4*8 +: 8] = 8'hC3;
    checkOutput("wr_regs", regs, expRegs);
    checkOutput("wr_stb_count", 128'(stbCount), 128'd2);
    checkOutput("wr_idx_first", 128'(stbIdx[0]), 128'd3);
    checkOutput("wr_idx_second", 128'(stbIdx[1]), 128'd4);

    $display("[TB] pointer write, repeated start, read two bytes");
    i2cStart();
    applyStimulus(8'hA0, ack); checkOutput("rd_addr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h03, ack); checkOutput("rd_ptr_ack", 128'(ack), 128'd0);
    i2cStart();
    applyStimulus(8'hA1, ack); checkOutput("rd_addr_r_ack", 128'(ack), 128'd0);
    readByte(rdByte, 1'b0);    checkOutput("rd_byte0", 128'(rdByte), 128'h5A);
    readByte(rdByte, 1'b1);    checkOutput("rd_byte1", 128'(rdByte), 128'hC3);
    quarter();
    checkOutput("rd_release_after_nack", 128'(sdaEn), 128'd0);
    i2cStop();
    checkOutput("rd_no_stb", 128'(stbCount), 128'd2);

    $display("[TB] pointer wrap 15 -> 0");
    i2cStart();
    applyStimulus(8'hA0, ack); checkOutput("wrap_addr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h0F, ack); checkOutput("wrap_ptr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h11, ack); checkOutput("wrap_d0_ack", 128'(ack), 128'd0);
    applyStimulus(8'h22, ack); checkOutput("wrap_d1_ack", 128'(ack), 128'd0);
    i2cStop();
    expRegs[15*8 +: 8] = 8'h11;
    expRegs[0 +: 8]    = 8'h22;
    checkOutput("wrap_regs", regs, expRegs);
    checkOutput("wrap_idx_first", 128'(stbIdx[2]), 128'd15);
    checkOutput("wrap_idx_second", 128'(stbIdx[3]), 128'd0);

    $display("[TB] wrong address 0xA2");
    stbBase = stbCount;
    enSeen  = 1'b0;
    i2cStart();
    applyStimulus(8'hA2, ack); checkOutput("bad_addr_nack", 128'(ack), 128'd1);
    applyStimulus(8'h02, ack); checkOutput("bad_ptr_nack", 128'(ack), 128'd1);
    applyStimulus(8'h99, ack); checkOutput("bad_data_nack", 128'(ack), 128'd1);
    i2cStop();
    checkOutput("bad_no_drive", 128'(enSeen), 128'd0);
    checkOutput("bad_no_stb", 128'(stbCount), 128'(stbBase));
    checkOutput("bad_regs", regs, expRegs);

    $display("[TB] reset during 5th bit of a read of C3");
    i2cStart();
    applyStimulus(8'hA0, ack); checkOutput("rr_addr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h04, ack); checkOutput("rr_ptr_ack", 128'(ack), 128'd0);
    i2cStart();
    applyStimulus(8'hA1, ack); checkOutput("rr_addr_r_ack", 128'(ack), 128'd0);
    for (int i = 3; i >= 0; i--) begin
      readBit(bitVal);
      partBits[i] = bitVal;
    end
    checkOutput("rr_first_nibble", 128'(partBits), 128'hC);
    sdaCtl = 1'b1; quarter();
    sclCtl = 1'b1; quarter();
    checkOutput("rr_driving_zero", 128'(sdaEn), 128'd1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rr_sda_released", 128'(sdaEn), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expRegs = '0;
    checkOutput("rr_regs_cleared", regs, expRegs);
    quarter();
    sclCtl = 1'b0; quarter();
    stbBase = stbCount;
    i2cStart();
    applyStimulus(8'hA0, ack); checkOutput("rr_next_addr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h01, ack); checkOutput("rr_next_ptr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h77, ack); checkOutput("rr_next_data_ack", 128'(ack), 128'd0);
    i2cStop();
    expRegs[1*8 +: 8] = 8'h77;
    checkOutput("rr_next_regs", regs, expRegs);
    checkOutput("rr_next_idx", 128'(stbIdx[stbBase]), 128'd1);

    $display("[TB] STOP after 4 data bits");
    stbBase = stbCount;
    i2cStart();
    applyStimulus(8'hA0, ack); checkOutput("es_addr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h05, ack); checkOutput("es_ptr_ack", 128'(ack), 128'd0);
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b1);
    writeBit(1'b0);
    i2cStop();
    checkOutput("es_regs", regs, expRegs);
    checkOutput("es_no_stb", 128'(stbCount), 128'(stbBase));
    checkOutput("es_released", 128'(sdaEn), 128'd0);
    i2cStart();
    applyStimulus(8'hA0, ack); checkOutput("es_after_addr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h05, ack); checkOutput("es_after_ptr_ack", 128'(ack), 128'd0);
    applyStimulus(8'h3C, ack); checkOutput("es_after_data_ack", 128'(ack), 128'd0);
    i2cStop();
    expRegs[5*8 +: 8] = 8'h3C;
    checkOutput("es_after_regs", regs, expRegs);
    checkOutput("es_after_stb", 128'(stbCount), 128'(stbBase + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
